// File: rtl/sirv_gnrl_pkg.sv
// Shared AXI encodings used by the sirv_gnrl ICB/AXI bridge blocks.
package sirv_gnrl_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    function automatic logic axi_resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/sirv_gnrl_icb_to_axi_dwc_fifo.sv
// Generic circular FIFO of depth DP; MSKO zeroes o_dat while empty.
// With CUT_READY=0 a same-cycle pop frees a slot for a push while full.
module sirv_gnrl_fifo #(
    parameter int unsigned CUT_READY = 0,
    parameter int unsigned MSKO      = 0,
    parameter int unsigned DP        = 8,
    parameter int unsigned DW        = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat
);
    localparam int unsigned PW = (DP > 1) ? $clog2(DP) : 1;
    localparam int unsigned CW = $clog2(DP + 1);

    logic [DW-1:0] r_mem [DP];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          w_full;
    logic          w_wen;
    logic          w_ren;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DP - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full = (r_cnt == CW'(DP));
    assign o_vld  = (r_cnt != '0);
    assign w_ren  = o_vld & o_rdy;
    assign i_rdy  = ~w_full | ((CUT_READY == 0) & w_ren);
    assign w_wen  = i_vld & i_rdy;
    assign o_dat  = (MSKO != 0) ? (r_mem[r_rptr] & {DW{o_vld}}) : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_wen) r_mem[r_wptr] <= i_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wen) r_wptr <= f_inc(r_wptr);
            if (w_ren) r_rptr <= f_inc(r_rptr);
            if (w_wen & ~w_ren)      r_cnt <= r_cnt + 1'b1;
            else if (~w_wen & w_ren) r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/sirv_gnrl_icb_to_axi_dwc.sv
// ICB-to-AXI4 bridge with data-width up-conversion; single-beat bursts only.
// A tracking FIFO of {read, lane} steers in-order responses back to the ICB.
module sirv_gnrl_icb_to_axi_dwc
    import sirv_gnrl_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned IDW       = 32,
    parameter int unsigned ODW       = 64,
    parameter int unsigned OUTS_NUM  = 8,
    parameter int unsigned CUT_READY = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_icb_cmd_valid,
    output logic                            i_icb_cmd_ready,
    input  logic                            i_icb_cmd_read,
    input  logic [AW-1:0]                   i_icb_cmd_addr,
    input  logic [IDW-1:0]                  i_icb_cmd_wdata,
    input  logic [IDW/8-1:0]                i_icb_cmd_wmask,
    input  logic [1:0]                      i_icb_cmd_size,
    output logic                            i_icb_rsp_valid,
    input  logic                            i_icb_rsp_ready,
    output logic                            i_icb_rsp_err,
    output logic [IDW-1:0]                  i_icb_rsp_rdata,
    output logic                            o_axi_arvalid,
    input  logic                            o_axi_arready,
    output logic [AW-1:0]                   o_axi_araddr,
    output logic [3:0]                      o_axi_arcache,
    output logic [2:0]                      o_axi_arprot,
    output logic                            o_axi_arlock,
    output logic [1:0]                      o_axi_arburst,
    output logic [7:0]                      o_axi_arlen,
    output logic [2:0]                      o_axi_arsize,
    output logic                            o_axi_awvalid,
    input  logic                            o_axi_awready,
    output logic [AW-1:0]                   o_axi_awaddr,
    output logic [3:0]                      o_axi_awcache,
    output logic [2:0]                      o_axi_awprot,
    output logic                            o_axi_awlock,
    output logic [1:0]                      o_axi_awburst,
    output logic [7:0]                      o_axi_awlen,
    output logic [2:0]                      o_axi_awsize,
    output logic                            o_axi_wvalid,
    input  logic                            o_axi_wready,
    output logic [ODW-1:0]                  o_axi_wdata,
    output logic [ODW/8-1:0]                o_axi_wstrb,
    output logic                            o_axi_wlast,
    input  logic                            o_axi_rvalid,
    output logic                            o_axi_rready,
    input  logic [ODW-1:0]                  o_axi_rdata,
    input  logic [1:0]                      o_axi_rresp,
    input  logic                            o_axi_rlast,
    input  logic                            o_axi_bvalid,
    output logic                            o_axi_bready,
    input  logic [1:0]                      o_axi_bresp,
    output logic [$clog2(OUTS_NUM+1)-1:0]   outs_cnt,
    output logic                            idle
);
    localparam int unsigned IB     = $clog2(IDW / 8);
    localparam int unsigned LW     = $clog2(ODW / IDW);
    localparam int unsigned LANE_W = (LW > 0) ? LW : 1;
    localparam int unsigned NLANE  = ODW / IDW;
    localparam int unsigned TDW    = 1 + LW;
    localparam int unsigned CNT_W  = $clog2(OUTS_NUM + 1);

    logic              r_aw_done;
    logic              r_w_done;
    logic [CNT_W-1:0]  r_outs_cnt;
    logic [LANE_W-1:0] w_cmd_lane;
    logic [LANE_W-1:0] w_head_lane;
    logic              w_head_read;
    logic [TDW-1:0]    w_trk_din;
    logic [TDW-1:0]    w_trk_dout;
    logic              w_trk_irdy;
    logic              w_trk_ovld;
    logic              w_trk_full;
    logic              w_wr_go;
    logic              w_cmd_hsk;
    logic              w_rsp_hsk;
    logic              w_head_rd;
    logic              w_head_wr;
    logic [AW-1:0]     w_axi_addr;
    logic [IDW-1:0]    w_rsp_lane_data;
    logic              w_unused;

    if (LW > 0) begin : g_lane
        assign w_cmd_lane  = i_icb_cmd_addr[IB +: LW];
        assign w_trk_din   = {i_icb_cmd_read, w_cmd_lane};
        assign w_head_read = w_trk_dout[LW];
        assign w_head_lane = w_trk_dout[LW-1:0];
    end else begin : g_nolane
        assign w_cmd_lane  = '0;
        assign w_trk_din   = i_icb_cmd_read;
        assign w_head_read = w_trk_dout[0];
        assign w_head_lane = '0;
    end

    assign w_axi_addr = {i_icb_cmd_addr[AW-1:IB], {IB{1'b0}}};
    assign w_unused   = ^{i_icb_cmd_size, o_axi_rlast, i_icb_cmd_addr[IB-1:0]};

    // Command path: AW/W valids never wait on ready; done flags stop re-issue.
    assign w_trk_full      = ~w_trk_irdy;
    assign w_wr_go         = i_icb_cmd_valid & ~i_icb_cmd_read & ~w_trk_full;
    assign o_axi_arvalid   = i_icb_cmd_valid & i_icb_cmd_read & ~w_trk_full;
    assign o_axi_awvalid   = w_wr_go & ~r_aw_done;
    assign o_axi_wvalid    = w_wr_go & ~r_w_done;
    assign i_icb_cmd_ready = ~w_trk_full & (i_icb_cmd_read ? o_axi_arready :
                             ((r_aw_done | o_axi_awready) & (r_w_done | o_axi_wready)));
    assign w_cmd_hsk       = i_icb_cmd_valid & i_icb_cmd_ready;

    assign o_axi_araddr  = w_axi_addr;
    assign o_axi_arcache = '0;
    assign o_axi_arprot  = '0;
    assign o_axi_arlock  = 1'b0;
    assign o_axi_arburst = AXI_BURST_INCR;
    assign o_axi_arlen   = '0;
    assign o_axi_arsize  = 3'(IB);
    assign o_axi_awaddr  = w_axi_addr;
    assign o_axi_awcache = '0;
    assign o_axi_awprot  = '0;
    assign o_axi_awlock  = 1'b0;
    assign o_axi_awburst = AXI_BURST_INCR;
    assign o_axi_awlen   = '0;
    assign o_axi_awsize  = 3'(IB);
    assign o_axi_wdata   = {NLANE{i_icb_cmd_wdata}};
    assign o_axi_wlast   = 1'b1;

    always_comb begin
        o_axi_wstrb     = '0;
        w_rsp_lane_data = '0;
        for (int unsigned j = 0; j < NLANE; j++) begin
            if (w_cmd_lane == LANE_W'(j))  o_axi_wstrb[j*(IDW/8) +: IDW/8] = i_icb_cmd_wmask;
            if (w_head_lane == LANE_W'(j)) w_rsp_lane_data = o_axi_rdata[j*IDW +: IDW];
        end
    end

    assign w_head_rd       = w_trk_ovld & w_head_read;
    assign w_head_wr       = w_trk_ovld & ~w_head_read;
    assign i_icb_rsp_valid = (w_head_rd & o_axi_rvalid) | (w_head_wr & o_axi_bvalid);
    assign o_axi_rready    = w_head_rd & i_icb_rsp_ready;
    assign o_axi_bready    = w_head_wr & i_icb_rsp_ready;
    assign i_icb_rsp_err   = (w_head_rd & axi_resp_is_err(o_axi_rresp)) |
                             (w_head_wr & axi_resp_is_err(o_axi_bresp));
    assign i_icb_rsp_rdata = w_head_rd ? w_rsp_lane_data : '0;
    assign w_rsp_hsk       = i_icb_rsp_valid & i_icb_rsp_ready;

    sirv_gnrl_fifo #(
        .CUT_READY (CUT_READY),
        .MSKO      (1),
        .DP        (OUTS_NUM),
        .DW        (TDW)
    ) u_trk_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .i_vld (w_cmd_hsk),
        .i_rdy (w_trk_irdy),
        .i_dat (w_trk_din),
        .o_vld (w_trk_ovld),
        .o_rdy (w_rsp_hsk),
        .o_dat (w_trk_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_outs_cnt <= '0;
        end else begin
            if (w_cmd_hsk)                          r_aw_done <= 1'b0;
            else if (o_axi_awvalid & o_axi_awready) r_aw_done <= 1'b1;
            if (w_cmd_hsk)                          r_w_done  <= 1'b0;
            else if (o_axi_wvalid & o_axi_wready)   r_w_done  <= 1'b1;
            if (w_cmd_hsk & ~w_rsp_hsk)      r_outs_cnt <= r_outs_cnt + 1'b1;
            else if (~w_cmd_hsk & w_rsp_hsk) r_outs_cnt <= r_outs_cnt - 1'b1;
        end
    end

    assign outs_cnt = r_outs_cnt;
    assign idle     = (r_outs_cnt == '0) & ~r_aw_done & ~r_w_done;

endmodule

// File: tb/tb_sirv_gnrl_icb_to_axi_dwc.sv
// Directed bench: DUT A is 32->64 with two outstanding, DUT B is 32->128 with four.
module tb_sirv_gnrl_icb_to_axi_dwc;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int checks = 0;
    int errors = 0;

    logic        a_cmd_valid, a_cmd_ready, a_cmd_read;
    logic [31:0] a_cmd_addr, a_cmd_wdata;
    logic [3:0]  a_cmd_wmask;
    logic [1:0]  a_cmd_size;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        a_arvalid, a_arready, a_arlock, a_awvalid, a_awready, a_awlock;
    logic [31:0] a_araddr, a_awaddr;
    logic [3:0]  a_arcache, a_awcache;
    logic [2:0]  a_arprot, a_awprot, a_arsize, a_awsize;
    logic [1:0]  a_arburst, a_awburst;
    logic [7:0]  a_arlen, a_awlen;
    logic        a_wvalid, a_wready, a_wlast;
    logic [63:0] a_wdata, a_rdata;
    logic [7:0]  a_wstrb;
    logic        a_rvalid, a_rready, a_rlast, a_bvalid, a_bready;
    logic [1:0]  a_rresp, a_bresp;
    logic [1:0]  a_outs_cnt;
    logic        a_idle;

    logic         b_cmd_valid, b_cmd_ready, b_cmd_read;
    logic [31:0]  b_cmd_addr, b_cmd_wdata;
    logic [3:0]   b_cmd_wmask;
    logic [1:0]   b_cmd_size;
    logic         b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0]  b_rsp_rdata;
    logic         b_arvalid, b_arready, b_arlock, b_awvalid, b_awready, b_awlock;
    logic [31:0]  b_araddr, b_awaddr;
    logic [3:0]   b_arcache, b_awcache;
    logic [2:0]   b_arprot, b_awprot, b_arsize, b_awsize;
    logic [1:0]   b_arburst, b_awburst;
    logic [7:0]   b_arlen, b_awlen;
    logic         b_wvalid, b_wready, b_wlast;
    logic [127:0] b_wdata, b_rdata;
    logic [15:0]  b_wstrb;
    logic         b_rvalid, b_rready, b_rlast, b_bvalid, b_bready;
    logic [1:0]   b_rresp, b_bresp;
    logic [2:0]   b_outs_cnt;
    logic         b_idle;

    sirv_gnrl_icb_to_axi_dwc #(.AW(32), .IDW(32), .ODW(64), .OUTS_NUM(2), .CUT_READY(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_icb_cmd_valid(a_cmd_valid), .i_icb_cmd_ready(a_cmd_ready), .i_icb_cmd_read(a_cmd_read),
        .i_icb_cmd_addr(a_cmd_addr), .i_icb_cmd_wdata(a_cmd_wdata), .i_icb_cmd_wmask(a_cmd_wmask),
        .i_icb_cmd_size(a_cmd_size), .i_icb_rsp_valid(a_rsp_valid), .i_icb_rsp_ready(a_rsp_ready),
        .i_icb_rsp_err(a_rsp_err), .i_icb_rsp_rdata(a_rsp_rdata),
        .o_axi_arvalid(a_arvalid), .o_axi_arready(a_arready), .o_axi_araddr(a_araddr),
        .o_axi_arcache(a_arcache), .o_axi_arprot(a_arprot), .o_axi_arlock(a_arlock),
        .o_axi_arburst(a_arburst), .o_axi_arlen(a_arlen), .o_axi_arsize(a_arsize),
        .o_axi_awvalid(a_awvalid), .o_axi_awready(a_awready), .o_axi_awaddr(a_awaddr),
        .o_axi_awcache(a_awcache), .o_axi_awprot(a_awprot), .o_axi_awlock(a_awlock),
        .o_axi_awburst(a_awburst), .o_axi_awlen(a_awlen), .o_axi_awsize(a_awsize),
        .o_axi_wvalid(a_wvalid), .o_axi_wready(a_wready), .o_axi_wdata(a_wdata),
        .o_axi_wstrb(a_wstrb), .o_axi_wlast(a_wlast),
        .o_axi_rvalid(a_rvalid), .o_axi_rready(a_rready), .o_axi_rdata(a_rdata),
        .o_axi_rresp(a_rresp), .o_axi_rlast(a_rlast),
        .o_axi_bvalid(a_bvalid), .o_axi_bready(a_bready), .o_axi_bresp(a_bresp),
        .outs_cnt(a_outs_cnt), .idle(a_idle)
    );

    sirv_gnrl_icb_to_axi_dwc #(.AW(32), .IDW(32), .ODW(128), .OUTS_NUM(4), .CUT_READY(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_icb_cmd_valid(b_cmd_valid), .i_icb_cmd_ready(b_cmd_ready), .i_icb_cmd_read(b_cmd_read),
        .i_icb_cmd_addr(b_cmd_addr), .i_icb_cmd_wdata(b_cmd_wdata), .i_icb_cmd_wmask(b_cmd_wmask),
        .i_icb_cmd_size(b_cmd_size), .i_icb_rsp_valid(b_rsp_valid), .i_icb_rsp_ready(b_rsp_ready),
        .i_icb_rsp_err(b_rsp_err), .i_icb_rsp_rdata(b_rsp_rdata),
        .o_axi_arvalid(b_arvalid), .o_axi_arready(b_arready), .o_axi_araddr(b_araddr),
        .o_axi_arcache(b_arcache), .o_axi_arprot(b_arprot), .o_axi_arlock(b_arlock),
        .o_axi_arburst(b_arburst), .o_axi_arlen(b_arlen), .o_axi_arsize(b_arsize),
        .o_axi_awvalid(b_awvalid), .o_axi_awready(b_awready), .o_axi_awaddr(b_awaddr),
        .o_axi_awcache(b_awcache), .o_axi_awprot(b_awprot), .o_axi_awlock(b_awlock),
        .o_axi_awburst(b_awburst), .o_axi_awlen(b_awlen), .o_axi_awsize(b_awsize),
        .o_axi_wvalid(b_wvalid), .o_axi_wready(b_wready), .o_axi_wdata(b_wdata),
        .o_axi_wstrb(b_wstrb), .o_axi_wlast(b_wlast),
        .o_axi_rvalid(b_rvalid), .o_axi_rready(b_rready), .o_axi_rdata(b_rdata),
        .o_axi_rresp(b_rresp), .o_axi_rlast(b_rlast),
        .o_axi_bvalid(b_bvalid), .o_axi_bready(b_bready), .o_axi_bresp(b_bresp),
        .outs_cnt(b_outs_cnt), .idle(b_idle)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_defaults();
        a_cmd_valid = 0; a_cmd_read = 0; a_cmd_addr = '0; a_cmd_wdata = '0; a_cmd_wmask = '0;
        a_cmd_size = 2'b10; a_rsp_ready = 1; a_arready = 1; a_awready = 1; a_wready = 1;
        a_rvalid = 0; a_rdata = '0; a_rresp = 0; a_rlast = 1; a_bvalid = 0; a_bresp = 0;
        b_cmd_valid = 0; b_cmd_read = 0; b_cmd_addr = '0; b_cmd_wdata = '0; b_cmd_wmask = '0;
        b_cmd_size = 2'b10; b_rsp_ready = 1; b_arready = 1; b_awready = 1; b_wready = 1;
        b_rvalid = 0; b_rdata = '0; b_rresp = 0; b_rlast = 1; b_bvalid = 0; b_bresp = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive_defaults();
        #2;
        checks++; if (a_outs_cnt !== 2'd0) begin errors++; $display("FAIL rst_a_outs got %0d exp 0", a_outs_cnt); end
        checks++; if (a_idle !== 1'b1) begin errors++; $display("FAIL rst_a_idle got %0b exp 1", a_idle); end
        checks++; if (b_outs_cnt !== 3'd0) begin errors++; $display("FAIL rst_b_outs got %0d exp 0", b_outs_cnt); end
        checks++; if (b_idle !== 1'b1) begin errors++; $display("FAIL rst_b_idle got %0b exp 1", b_idle); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        tick();
        checks++; if ({a_arvalid, a_awvalid, a_wvalid, a_rsp_valid} !== 4'b0) begin errors++; $display("FAIL rst_a_valids got %b exp 0000", {a_arvalid, a_awvalid, a_wvalid, a_rsp_valid}); end
        checks++; if ({b_arvalid, b_awvalid, b_wvalid, b_rsp_valid} !== 4'b0) begin errors++; $display("FAIL rst_b_valids got %b exp 0000", {b_arvalid, b_awvalid, b_wvalid, b_rsp_valid}); end
    endtask

    task automatic test_read();
        tick();
        a_cmd_valid = 1; a_cmd_read = 1; a_cmd_addr = 32'h1004; a_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        checks++; if (a_arvalid !== 1'b1) begin errors++; $display("FAIL rd_arvalid got %0b exp 1", a_arvalid); end
        checks++; if (a_araddr !== 32'h1004) begin errors++; $display("FAIL rd_araddr got %h exp 00001004", a_araddr); end
        checks++; if (a_arsize !== 3'd2) begin errors++; $display("FAIL rd_arsize got %0d exp 2", a_arsize); end
        checks++; if ({a_arlen, a_arburst, a_arcache, a_arprot, a_arlock} !== {8'h0, 2'b01, 4'h0, 3'h0, 1'b0}) begin errors++; $display("FAIL rd_arattr got %h exp 004000", {a_arlen, a_arburst, a_arcache, a_arprot, a_arlock}); end
        checks++; if ({a_cmd_ready, a_awvalid, a_wvalid} !== 3'b100) begin errors++; $display("FAIL rd_ready got %b exp 100", {a_cmd_ready, a_awvalid, a_wvalid}); end
        tick();
        a_cmd_valid = 0; a_rvalid = 1; a_rresp = 2'b00;
        #1;
        checks++; if (a_outs_cnt !== 2'd1) begin errors++; $display("FAIL rd_outs got %0d exp 1", a_outs_cnt); end
        checks++; if (a_rsp_rdata !== 32'hAAAA_BBBB) begin errors++; $display("FAIL rd_rdata got %h exp aaaabbbb", a_rsp_rdata); end
        checks++; if ({a_rsp_valid, a_rsp_err, a_rready, a_bready} !== 4'b1010) begin errors++; $display("FAIL rd_rsp got %b exp 1010", {a_rsp_valid, a_rsp_err, a_rready, a_bready}); end
        tick();
        a_rvalid = 0;
        #1;
        checks++; if ({a_outs_cnt, a_idle} !== 3'b001) begin errors++; $display("FAIL rd_drain got %b exp 001", {a_outs_cnt, a_idle}); end
    endtask

    task automatic test_write_w_first();
        tick();
        a_cmd_valid = 1; a_cmd_read = 0; a_cmd_addr = 32'h2000; a_cmd_wdata = 32'h1234_5678;
        a_cmd_wmask = 4'b0011; a_awready = 0; a_wready = 1;
        #1;
        checks++; if ({a_awvalid, a_wvalid, a_wlast, a_cmd_ready} !== 4'b1110) begin errors++; $display("FAIL wr_c0 got %b exp 1110", {a_awvalid, a_wvalid, a_wlast, a_cmd_ready}); end
        checks++; if (a_wstrb !== 8'h03) begin errors++; $display("FAIL wr_wstrb got %h exp 03", a_wstrb); end
        checks++; if (a_wdata !== 64'h1234_5678_1234_5678) begin errors++; $display("FAIL wr_wdata got %h exp 1234567812345678", a_wdata); end
        checks++; if ({a_awaddr, a_awsize, a_awburst} !== {32'h2000, 3'd2, 2'b01}) begin errors++; $display("FAIL wr_aw got %h exp 2000/2/1", {a_awaddr, a_awsize, a_awburst}); end
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++; if ({a_awvalid, a_wvalid, a_cmd_ready, a_idle} !== 4'b1000) begin errors++; $display("FAIL wr_c%0d got %b exp 1000", c, {a_awvalid, a_wvalid, a_cmd_ready, a_idle}); end
        end
        tick();
        a_awready = 1;
        #1;
        checks++; if ({a_awvalid, a_wvalid, a_cmd_ready} !== 3'b101) begin errors++; $display("FAIL wr_c3 got %b exp 101", {a_awvalid, a_wvalid, a_cmd_ready}); end
        tick();
        a_cmd_valid = 0; a_bvalid = 1;
        #1;
        checks++; if ({a_outs_cnt, a_idle} !== 3'b010) begin errors++; $display("FAIL wr_outs got %b exp 010", {a_outs_cnt, a_idle}); end
        checks++; if ({a_rsp_valid, a_rsp_err, a_bready, a_rready} !== 4'b1010 || a_rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp got %b/%h exp 1010/0", {a_rsp_valid, a_rsp_err, a_bready, a_rready}, a_rsp_rdata); end
        tick();
        a_bvalid = 0;
        #1;
        checks++; if ({a_outs_cnt, a_idle} !== 3'b001) begin errors++; $display("FAIL wr_drain got %b exp 001", {a_outs_cnt, a_idle}); end
    endtask

    task automatic test_write_aw_first();
        tick();
        a_cmd_valid = 1; a_cmd_read = 0; a_cmd_addr = 32'h2004; a_cmd_wdata = 32'hCAFE_0001;
        a_cmd_wmask = 4'b1100; a_awready = 1; a_wready = 0;
        #1;
        checks++; if ({a_awvalid, a_wvalid, a_cmd_ready} !== 3'b110) begin errors++; $display("FAIL awf_c0 got %b exp 110", {a_awvalid, a_wvalid, a_cmd_ready}); end
        checks++; if (a_wstrb !== 8'hC0) begin errors++; $display("FAIL awf_wstrb got %h exp c0", a_wstrb); end
        tick();
        checks++; if ({a_awvalid, a_wvalid, a_cmd_ready} !== 3'b010) begin errors++; $display("FAIL awf_c1 got %b exp 010", {a_awvalid, a_wvalid, a_cmd_ready}); end
        tick();
        a_wready = 1;
        #1;
        checks++; if ({a_awvalid, a_wvalid, a_cmd_ready} !== 3'b011) begin errors++; $display("FAIL awf_c2 got %b exp 011", {a_awvalid, a_wvalid, a_cmd_ready}); end
        tick();
        a_cmd_valid = 0; a_bvalid = 1;
        #1;
        checks++; if (a_rsp_valid !== 1'b1) begin errors++; $display("FAIL awf_rsp got %0b exp 1", a_rsp_valid); end
        tick();
        a_bvalid = 0;
        #1;
        checks++; if ({a_outs_cnt, a_idle} !== 3'b001) begin errors++; $display("FAIL awf_drain got %b exp 001", {a_outs_cnt, a_idle}); end
    endtask

    task automatic test_order_err();
        tick();
        a_cmd_valid = 1; a_cmd_read = 0; a_cmd_addr = 32'h3000; a_cmd_wmask = 4'hF; a_awready = 1; a_wready = 1;
        #1;
        checks++; if ({a_awvalid, a_wvalid, a_cmd_ready} !== 3'b111) begin errors++; $display("FAIL ord_wr got %b exp 111", {a_awvalid, a_wvalid, a_cmd_ready}); end
        tick();
        a_cmd_read = 1; a_cmd_addr = 32'h300C;
        #1;
        checks++; if ({a_arvalid, a_cmd_ready, a_outs_cnt} !== 4'b1101) begin errors++; $display("FAIL ord_rd got %b exp 1101", {a_arvalid, a_cmd_ready, a_outs_cnt}); end
        tick();
        a_cmd_valid = 0; a_rvalid = 1; a_rdata = 64'h5555_6666_7777_8888;
        #1;
        checks++; if ({a_outs_cnt, a_rready, a_rsp_valid} !== 4'b1000) begin errors++; $display("FAIL ord_hold0 got %b exp 1000", {a_outs_cnt, a_rready, a_rsp_valid}); end
        tick();
        checks++; if ({a_rready, a_rsp_valid} !== 2'b00) begin errors++; $display("FAIL ord_hold1 got %b exp 00", {a_rready, a_rsp_valid}); end
        a_bvalid = 1; a_bresp = 2'b10;
        #1;
        checks++; if ({a_rsp_valid, a_rsp_err, a_bready, a_rready} !== 4'b1110 || a_rsp_rdata !== 32'h0) begin errors++; $display("FAIL ord_b got %b/%h exp 1110/0", {a_rsp_valid, a_rsp_err, a_bready, a_rready}, a_rsp_rdata); end
        tick();
        a_bvalid = 0; a_bresp = 2'b00;
        #1;
        checks++; if ({a_rsp_valid, a_rsp_err, a_rready, a_bready} !== 4'b1010 || a_outs_cnt !== 2'd1) begin errors++; $display("FAIL ord_r got %b/%0d exp 1010/1", {a_rsp_valid, a_rsp_err, a_rready, a_bready}, a_outs_cnt); end
        checks++; if (a_rsp_rdata !== 32'h5555_6666) begin errors++; $display("FAIL ord_rdata got %h exp 55556666", a_rsp_rdata); end
        tick();
        a_rvalid = 0;
        #1;
        checks++; if (a_outs_cnt !== 2'd0) begin errors++; $display("FAIL ord_drain got %0d exp 0", a_outs_cnt); end
    endtask

    task automatic test_outstanding();
        tick();
        a_cmd_valid = 1; a_cmd_read = 1; a_cmd_addr = 32'h10; a_arready = 1;
        #1;
        checks++; if (a_cmd_ready !== 1'b1) begin errors++; $display("FAIL os_r1 got %0b exp 1", a_cmd_ready); end
        tick();
        a_cmd_addr = 32'h18;
        #1;
        checks++; if ({a_cmd_ready, a_outs_cnt} !== 3'b101) begin errors++; $display("FAIL os_r2 got %b exp 101", {a_cmd_ready, a_outs_cnt}); end
        tick();
        a_cmd_addr = 32'h24;
        #1;
        checks++; if ({a_cmd_ready, a_arvalid, a_outs_cnt} !== 4'b0010) begin errors++; $display("FAIL os_stall0 got %b exp 0010", {a_cmd_ready, a_arvalid, a_outs_cnt}); end
        tick();
        checks++; if ({a_cmd_ready, a_arvalid, a_outs_cnt} !== 4'b0010) begin errors++; $display("FAIL os_stall1 got %b exp 0010", {a_cmd_ready, a_arvalid, a_outs_cnt}); end
        a_rvalid = 1; a_rdata = 64'h0000_0002_0000_0001;
        #1;
        checks++; if ({a_rsp_valid, a_cmd_ready, a_arvalid} !== 3'b111 || a_rsp_rdata !== 32'h1) begin errors++; $display("FAIL os_unblock got %b/%h exp 111/1", {a_rsp_valid, a_cmd_ready, a_arvalid}, a_rsp_rdata); end
        tick();
        a_cmd_valid = 0; a_rdata = 64'h0000_0004_0000_0003;
        #1;
        checks++; if (a_outs_cnt !== 2'd2 || a_rsp_rdata !== 32'h3) begin errors++; $display("FAIL os_pp got %0d/%h exp 2/3", a_outs_cnt, a_rsp_rdata); end
        tick();
        a_rdata = 64'h0000_0006_0000_0005;
        #1;
        checks++; if (a_outs_cnt !== 2'd1 || a_rsp_rdata !== 32'h6) begin errors++; $display("FAIL os_r3 got %0d/%h exp 1/6", a_outs_cnt, a_rsp_rdata); end
        tick();
        a_rvalid = 0;
        #1;
        checks++; if ({a_outs_cnt, a_idle} !== 3'b001) begin errors++; $display("FAIL os_drain got %b exp 001", {a_outs_cnt, a_idle}); end
    endtask

    task automatic test_wide_lane();
        tick();
        b_cmd_valid = 1; b_cmd_read = 1; b_cmd_addr = 32'h0C;
        #1;
        checks++; if ({b_araddr, b_arsize, b_cmd_ready} !== {32'h0C, 3'd2, 1'b1}) begin errors++; $display("FAIL wide_ar got %h exp 0000000c/2/1", {b_araddr, b_arsize, b_cmd_ready}); end
        tick();
        b_cmd_valid = 0; b_rvalid = 1; b_rdata = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
        #1;
        checks++; if (b_rsp_rdata !== 32'hDDDD0003) begin errors++; $display("FAIL wide_rdata got %h exp dddd0003", b_rsp_rdata); end
        tick();
        b_rvalid = 0;
        #1;
        checks++; if (b_outs_cnt !== 3'd0) begin errors++; $display("FAIL wide_drain got %0d exp 0", b_outs_cnt); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            tick();
            b_cmd_valid = 1; b_cmd_read = 1; b_cmd_addr = 32'(k * 4);
            #1;
            checks++; if (b_cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_rd%0d got %0b exp 1", k, b_cmd_ready); end
        end
        tick();
        b_cmd_read = 0; b_cmd_addr = 32'h08; b_cmd_wdata = 32'hCAFE_F00D; b_cmd_wmask = 4'hF;
        b_awready = 1; b_wready = 0;
        #1;
        checks++; if (b_wstrb !== 16'h0F00) begin errors++; $display("FAIL rm_wstrb got %h exp 0f00", b_wstrb); end
        checks++; if (b_wdata !== {4{32'hCAFE_F00D}}) begin errors++; $display("FAIL rm_wdata got %h exp cafef00d x4", b_wdata); end
        checks++; if ({b_awvalid, b_outs_cnt} !== 4'b1011) begin errors++; $display("FAIL rm_aw got %b exp 1011", {b_awvalid, b_outs_cnt}); end
        tick();
        checks++; if ({b_awvalid, b_wvalid, b_idle} !== 3'b010) begin errors++; $display("FAIL rm_awdone got %b exp 010", {b_awvalid, b_wvalid, b_idle}); end
        rst_n = 0; b_cmd_valid = 0;
        #1;
        checks++; if ({b_outs_cnt, b_idle} !== 4'b0001) begin errors++; $display("FAIL rm_async got %b exp 0001", {b_outs_cnt, b_idle}); end
        tick();
        rst_n = 1;
        #1;
        checks++; if ({b_outs_cnt, b_idle} !== 4'b0001) begin errors++; $display("FAIL rm_after got %b exp 0001", {b_outs_cnt, b_idle}); end
        tick();
        b_cmd_valid = 1; b_awready = 0; b_wready = 0; b_rvalid = 1;
        #1;
        checks++; if ({b_awvalid, b_wvalid, b_rsp_valid, b_rready} !== 4'b1100) begin errors++; $display("FAIL rm_flags got %b exp 1100", {b_awvalid, b_wvalid, b_rsp_valid, b_rready}); end
        tick();
        b_cmd_valid = 0; b_rvalid = 0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_w_first();
        test_write_aw_first();
        test_order_err();
        test_outstanding();
        test_wide_lane();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
